spi_divider: RTL and testbench
==============================

Name: spi_divider

Overview:
- SPI slave functional unit that performs 32-bit unsigned division and remainder for the CPU.
- Sits beside the ALU, multiplier and barrel shifter as a fourth slave. The CPU's SPI master drives it over an spi_if SLAVE modport.
- Frame format matches the existing slaves:
  - 4-bit opcode
  - 32-bit operand A
  - 32-bit operand B
  - WAIT_BITS idle sclk cycles
  - 32-bit result returned MSB-first on miso.
- Internally it deserialises the frame, runs an iterative divider during the wait window, then serialises the result.

Parameters:
DATA_WIDTH, 32, operand/result width
OP_WIDTH, 4, opcode field width
WAIT_BITS, 8, sclk rising edges between last B bit and first result bit
OP_DIV, 4'hA, opcode returning quotient A/B
OP_REM, 4'hB, opcode returning remainder A%B

Ports:
clock  input  1  system clock; sclk/mosi/nss are synchronous to it
reset  input  1  asynchronous, active-low reset
spi.sclk  input  1  serial clock from master, idle 0
spi.mosi  input  1  serial data from master, MSB-first
spi.nss  input  1  slave select, active-low
spi.miso  output  1  serial result to master
overrun  output  1  one-cycle pulse: wait window ended before divider finished

Behaviour:
- Reset (reset=0, async):
  - miso=0, overrun=0, state=IDLE
  - all shift registers and counters = 0; divider idle.
- Edge detection:
  - Register sclk once (sclk_q); rise = sclk & ~sclk_q.
  - No synchronizers: all inputs come from the same clock domain.
  - All actions below occur on the clock edge where rise=1.
- nss=1 in any state:
  - Next cycle: state=IDLE, miso=0, bit counter=0, divider aborted.
  - No overrun pulse on abort.
- States:
  - IDLE: when nss=0, go to RX_OP, counter=0.
  - RX_OP: on each rise shift mosi into op_sr. After 4th rise -> RX_A.
  - RX_A: on each rise shift mosi into a_sr. After 32nd rise -> RX_B.
  - RX_B: on each rise shift mosi into b_sr. On 32nd rise:
    - latch op;
    - assert divider start for one cycle with A=a_sr and B={b_sr[30:0],mosi};
    - go to WAIT.
  - WAIT: count WAIT_BITS rises. On the last one:
    - load tx_sr with the selected result;
    - drive miso=tx_sr[31] on that same edge;
    - go to TX.
    - If the divider is not done at that point: result=0 and overrun pulses 1 cycle.
  - TX: on each rise shift tx_sr left and drive the next bit. Master samples on its falling edge, between rises. After 31 shifts -> DONE.
  - DONE: miso=0 until nss=1.
- Result selection:
  - OP_DIV -> quotient.
  - OP_REM -> remainder.
  - Any other opcode -> 32'h0 and the divider is not started. Framing is unchanged.
- Division:
  - Unsigned, restoring, one quotient bit per clock.
  - Latency: done asserted exactly DATA_WIDTH+1 = 33 clocks after start.
  - Default timing: sclk period 8 clocks, so the wait window is 64 clocks (>33). No overrun under nominal timing.
- Divide by zero (B=0): quotient=32'hFFFFFFFF, remainder=A. Same latency, no overrun.
- A<B: quotient=0, remainder=A.
- Back-to-back frames: a new frame starts only after nss returns high (≥1 clock) then low again.

Decomposition:
- Package spi_div_pkg holds:
  - state enum (IDLE, RX_OP, RX_A, RX_B, WAIT, TX, DONE);
  - OP_DIV and OP_REM constants;
  - DATA_WIDTH and OP_WIDTH defaults.
- Extend the CPU's opcode list with the same constants from this package.
- One sub-module, seq_divider: ports clock, reset, start, dividend, divisor, busy, done, quotient, remainder.
  - done is a 1-cycle pulse; outputs hold until the next start.
  - Handles B=0 internally.

Test Plan:
- Frame op=4'hA, A=100, B=7, sclk period 8 clocks -> master receives 32'd14, overrun stays 0.
- Same operands with op=4'hB -> 32'd2; separately A=32'hFFFFFFFF, B=1, op=A -> 32'hFFFFFFFF.
- op=4'hA, A=1234, B=0 -> 32'hFFFFFFFF; op=4'hB, A=1234, B=0 -> 32'd1234.
- op=4'h3 (unsupported), A=5, B=5 -> 32'h0, divider start never asserted.
- nss raised after 10 bits of A, then full frame op=A, A=81, B=9 -> 32'd9, no residue from the aborted frame.
- sclk period 2 clocks (wait window 16 clocks < 33), op=A -> result 32'h0 and a single overrun pulse; reset asserted mid-TX -> miso=0 and state=IDLE immediately.

Source files
------------

// File: rtl/spi_div_pkg.sv
// Shared definitions for the SPI divider slave: frame-phase states, opcodes and
// default widths. The CPU opcode list reuses OP_DIV/OP_REM from here.
package spi_div_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_OP_WIDTH   = 4;

    localparam logic [DEFAULT_OP_WIDTH-1:0] OP_DIV = 4'hA;
    localparam logic [DEFAULT_OP_WIDTH-1:0] OP_REM = 4'hB;

    typedef enum logic [2:0] {
        IDLE,
        RX_OP,
        RX_A,
        RX_B,
        WAIT,
        TX,
        DONE
    } state_t;

endpackage

// File: rtl/spi_if.sv
// SPI bus bundle shared by the CPU master and its functional-unit slaves.
interface spi_if;
    logic sclk;
    logic mosi;
    logic nss;
    logic miso;

    modport SLAVE  (input sclk, mosi, nss, output miso);
    modport MASTER (output sclk, mosi, nss, input miso);
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, done pulses
// WIDTH+1 clocks after start, results hold until the next start.
module seq_divider
    import spi_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int STEP_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  rem_w;
    logic [WIDTH-1:0]  quo_w;
    logic [WIDTH-1:0]  dvs;
    logic [STEP_W-1:0] step;
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    diff;
    logic              ge;

    // A zero divisor always "fits", so the algorithm itself yields all-ones / A.
    assign shifted = {rem_w, quo_w[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign ge      = ~diff[WIDTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_w     <= '0;
            quo_w     <= '0;
            dvs       <= '0;
            step      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_w <= '0;
                quo_w <= dividend;
                dvs   <= divisor;
                step  <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                if (step == STEP_W'(WIDTH)) begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    quotient  <= quo_w;
                    remainder <= rem_w;
                end else begin
                    rem_w <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo_w <= {quo_w[WIDTH-2:0], ge};
                    step  <= step + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_divider.sv
// SPI slave that receives {op, A, B}, divides during the idle window and
// shifts the quotient or remainder back MSB-first.
module spi_divider
    import spi_div_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OP_WIDTH   = DEFAULT_OP_WIDTH,
    parameter int WAIT_BITS  = 8
) (
    input  logic clock,
    input  logic reset,
    spi_if.SLAVE spi,
    output logic overrun
);
    localparam int CNT_W = $clog2(DATA_WIDTH + WAIT_BITS + OP_WIDTH + 1);

    state_t                state, state_next;
    logic                  sclk_q;
    logic                  rise;
    logic                  last_bit;
    logic [CNT_W-1:0]      cnt, limit;
    logic [OP_WIDTH-1:0]   op_sr, op_q;
    logic [DATA_WIDTH-1:0] a_sr, b_sr, result;
    logic [DATA_WIDTH-2:0] tx_sr;
    logic                  div_start, div_busy, div_done, res_valid;
    logic [DATA_WIDTH-1:0] quotient, remainder;
    logic                  op_div, op_rem, op_valid, rx_op_valid;

    assign rise        = spi.sclk & ~sclk_q;
    assign op_div      = (op_q == OP_WIDTH'(OP_DIV));
    assign op_rem      = (op_q == OP_WIDTH'(OP_REM));
    assign op_valid    = op_div | op_rem;
    assign rx_op_valid = (op_sr == OP_WIDTH'(OP_DIV)) | (op_sr == OP_WIDTH'(OP_REM));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            RX_OP:      limit = CNT_W'(OP_WIDTH - 1);
            RX_A, RX_B: limit = CNT_W'(DATA_WIDTH - 1);
            WAIT:       limit = CNT_W'(WAIT_BITS - 1);
            TX:         limit = CNT_W'(DATA_WIDTH - 2);
            default:    limit = '0;
        endcase
        last_bit = rise && (cnt == limit);

        case (state)
            IDLE:    if (!spi.nss) state_next = RX_OP;
            RX_OP:   if (last_bit) state_next = RX_A;
            RX_A:    if (last_bit) state_next = RX_B;
            RX_B:    if (last_bit) state_next = WAIT;
            WAIT:    if (last_bit) state_next = TX;
            TX:      if (last_bit) state_next = DONE;
            default: ;
        endcase
        if (spi.nss) state_next = IDLE;
    end

    // Result is zero unless the divider has finished for this frame's operands.
    always_comb begin
        result = '0;
        if (res_valid || div_done) begin
            if (op_div)      result = quotient;
            else if (op_rem) result = remainder;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sclk_q    <= 1'b0;
            cnt       <= '0;
            op_sr     <= '0;
            op_q      <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            tx_sr     <= '0;
            div_start <= 1'b0;
            res_valid <= 1'b0;
            spi.miso  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sclk_q    <= spi.sclk;
            div_start <= 1'b0;
            overrun   <= 1'b0;
            if (div_done) res_valid <= 1'b1;

            if (spi.nss) begin
                cnt       <= '0;
                spi.miso  <= 1'b0;
                res_valid <= 1'b0;
            end else if (rise) begin
                if (state inside {RX_OP, RX_A, RX_B, WAIT, TX})
                    cnt <= last_bit ? '0 : cnt + 1'b1;
                case (state)
                    RX_OP: op_sr <= {op_sr[OP_WIDTH-2:0], spi.mosi};
                    RX_A:  a_sr  <= {a_sr[DATA_WIDTH-2:0], spi.mosi};
                    RX_B: begin
                        b_sr <= {b_sr[DATA_WIDTH-2:0], spi.mosi};
                        if (last_bit) begin
                            op_q      <= op_sr;
                            res_valid <= 1'b0;
                            div_start <= rx_op_valid;
                        end
                    end
                    WAIT: if (last_bit) begin
                        tx_sr    <= result[DATA_WIDTH-2:0];
                        spi.miso <= result[DATA_WIDTH-1];
                        overrun  <= op_valid & (div_start | div_busy);
                    end
                    TX: begin
                        tx_sr    <= {tx_sr[DATA_WIDTH-3:0], 1'b0};
                        spi.miso <= tx_sr[DATA_WIDTH-2];
                    end
                    DONE:    spi.miso <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    seq_divider #(.WIDTH(DATA_WIDTH)) u_div (
        .clock     (clock),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a_sr),
        .divisor   (b_sr),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

endmodule

// File: tb/tb_spi_divider.sv
// Drives SPI frames into spi_divider and compares the shifted-back result with
// plain-arithmetic division done in the bench.
module tb_spi_divider;
    import spi_div_pkg::*;

    localparam int DW          = 32;
    localparam int WAIT_BITS   = 8;
    localparam int FRAME_RISES = 4 + 2 * DW + WAIT_BITS + DW - 1;
    localparam int FIRST_RX    = 4 + 2 * DW + WAIT_BITS;

    logic clock = 1'b0;
    logic reset;
    logic overrun;
    spi_if spi_bus ();

    int n_checks     = 0;
    int n_errors     = 0;
    int ovr_pulses   = 0;
    int start_pulses = 0;

    spi_divider #(.DATA_WIDTH(DW), .OP_WIDTH(4), .WAIT_BITS(WAIT_BITS)) dut (
        .clock   (clock),
        .reset   (reset),
        .spi     (spi_bus),
        .overrun (overrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (overrun)       ovr_pulses++;
        if (dut.div_start) start_pulses++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit model_supported(input logic [3:0] op);
        return (op == 4'hA) || (op == 4'hB);
    endfunction

    // Wait window in clocks vs. divider latency decides whether the answer is ready.
    function automatic bit model_overrun(input logic [3:0] op, input int half);
        return model_supported(op) && (WAIT_BITS * 2 * half <= DW + 1);
    endfunction

    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                 input logic [31:0] b, input int half);
        if (model_overrun(op, half)) return 32'h0;
        case (op)
            4'hA:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'hB:    return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Plays one frame; stops after rise cut_at (0 = complete frame, then nss high).
    task automatic run_frame(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int half, input int cut_at, output logic [31:0] got);
        logic [67:0] bits;
        bits = {op, a, b};
        got  = '0;
        @(negedge clock);
        spi_bus.sclk = 1'b0;
        spi_bus.nss  = 1'b0;
        repeat (2) @(negedge clock);
        for (int r = 1; r <= FRAME_RISES; r++) begin
            spi_bus.mosi = (r <= 68) ? bits[68-r] : 1'b0;
            repeat (half) @(negedge clock);
            spi_bus.sclk = 1'b1;
            repeat (half) @(negedge clock);
            spi_bus.sclk = 1'b0;
            if (r >= FIRST_RX) got = {got[30:0], spi_bus.miso};
            if (r == cut_at) return;
        end
        spi_bus.mosi = 1'b0;
        repeat (2) @(negedge clock);
        spi_bus.nss = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic check_frame(input string tag, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int half);
        logic [31:0] got;
        int ov0, st0;
        ov0 = ovr_pulses;
        st0 = start_pulses;
        run_frame(op, a, b, half, 0, got);
        check({tag, "_result"}, got, model_result(op, a, b, half));
        check({tag, "_overrun"}, 32'(ovr_pulses - ov0), model_overrun(op, half) ? 32'd1 : 32'd0);
        check({tag, "_start"}, 32'(start_pulses - st0), model_supported(op) ? 32'd1 : 32'd0);
        check({tag, "_miso_idle"}, {31'b0, spi_bus.miso}, 32'h0);
    endtask

    initial begin
        logic [31:0] dummy;
        logic [3:0]  op;
        logic [31:0] a, b;
        int          half;

        reset        = 1'b0;
        spi_bus.sclk = 1'b0;
        spi_bus.mosi = 1'b0;
        spi_bus.nss  = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_miso", {31'b0, spi_bus.miso}, 32'h0);
        check("reset_overrun", {31'b0, overrun}, 32'h0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b1;
        repeat (2) @(negedge clock);

        check_frame("div_100_7", 4'hA, 32'd100, 32'd7, 4);
        check_frame("rem_100_7", 4'hB, 32'd100, 32'd7, 4);
        check_frame("div_max_1", 4'hA, 32'hFFFF_FFFF, 32'd1, 4);
        check_frame("div_by_0", 4'hA, 32'd1234, 32'd0, 4);
        check_frame("rem_by_0", 4'hB, 32'd1234, 32'd0, 4);
        check_frame("bad_op", 4'h3, 32'd5, 32'd5, 4);
        check_frame("div_a_lt_b", 4'hA, 32'd5, 32'd100, 4);
        check_frame("rem_a_lt_b", 4'hB, 32'd5, 32'd100, 4);

        // Abort after 10 bits of A, then a clean frame must not see any residue.
        run_frame(4'hA, 32'hDEAD_BEEF, 32'd3, 4, 14, dummy);
        repeat (2) @(negedge clock);
        spi_bus.nss = 1'b1;
        repeat (2) @(negedge clock);
        check("abort_state", 32'(dut.state), 32'(IDLE));
        check("abort_miso", {31'b0, spi_bus.miso}, 32'h0);
        check_frame("after_abort", 4'hA, 32'd81, 32'd9, 4);

        check_frame("fast_sclk", 4'hA, 32'd100, 32'd7, 1);

        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                1:       op = 4'hB;
                2:       op = 4'($urandom);
                default: op = 4'hA;
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                2:       b = $urandom;
                default: b = a >> $urandom_range(0, 31);
            endcase
            half = $urandom_range(1, 4);
            check_frame($sformatf("rand%0d", i), op, a, b, half);
        end

        // Reset in the middle of the result shift-out.
        run_frame(4'hA, 32'd100, 32'd7, 4, FIRST_RX + 9, dummy);
        reset = 1'b0;
        #1;
        check("midtx_reset_miso", {31'b0, spi_bus.miso}, 32'h0);
        check("midtx_reset_state", 32'(dut.state), 32'(IDLE));
        @(negedge clock);
        spi_bus.nss = 1'b1;
        reset       = 1'b1;
        repeat (3) @(negedge clock);
        check_frame("after_reset", 4'hB, 32'd1000, 32'd33, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
